// File: rtl/alu_op_sequencer.sv
// Front-panel sequencer for the 4-bit ALU: debounced step button, operand/op
// capture, result latch, and an optional timed auto-step through all ops.
module alu_op_sequencer #(
  parameter int DEB_CYCLES  = 500000,
  parameter int AUTO_CYCLES = 50000000,
  parameter int ALU_LAT     = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] sw_i,
  input  logic [2:0] sel_sw_i,
  input  logic       btn_i,
  input  logic       auto_i,
  input  logic [3:0] alu_res_i,
  input  logic       alu_carry_i,
  output logic [3:0] a_o,
  output logic [3:0] b_o,
  output logic [2:0] sel_o,
  output logic [3:0] res_o,
  output logic       cambio_o,
  output logic [1:0] state_o,
  output logic       valid_o
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(AUTO_CYCLES + 1);
  localparam int LW = $clog2(ALU_LAT + 1);

  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES);
  localparam logic [TW-1:0] AUTO_LAST = TW'(AUTO_CYCLES - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(ALU_LAT - 1);

  localparam logic [1:0] S_LOAD_A = 2'd0;
  localparam logic [1:0] S_LOAD_B = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_SHOW   = 2'd3;

  logic          btn_s1_q, btn_s2_q, acc_q, press_q;
  logic [DW-1:0] deb_cnt_q;

  logic [1:0]    state_q, state_d;
  logic [3:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]    sel_q, sel_d;
  logic          cy_q, cy_d, valid_q, valid_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [TW-1:0] tmr_q, tmr_d;

  // Button synchroniser and debouncer; PRESS fires once per accepted rising level.
  // The flip happens on the cycle after the count has reached DEB_CYCLES, so a
  // clean rise reaches PRESS DEB_CYCLES+3 edges after it is first sampled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_s1_q  <= 1'b0;
      btn_s2_q  <= 1'b0;
      acc_q     <= 1'b0;
      press_q   <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      btn_s1_q <= btn_i;
      btn_s2_q <= btn_s1_q;
      press_q  <= 1'b0;
      if (btn_s2_q != acc_q) begin
        if (deb_cnt_q == DEB_MAX) begin
          acc_q     <= btn_s2_q;
          deb_cnt_q <= '0;
          press_q   <= btn_s2_q;
        end else begin
          deb_cnt_q <= deb_cnt_q + DW'(1);
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  // Step FSM: next-state, operand capture, result latch and auto-step timer.
  // A press in EXEC falls through untouched and is therefore dropped.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    res_d   = res_q;
    cy_d    = cy_q;
    valid_d = 1'b0;
    lat_d   = '0;
    tmr_d   = '0;
    case (state_q)
      S_LOAD_A: begin
        if (press_q) begin
          a_d     = sw_i;
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (press_q) begin
          b_d     = sw_i;
          sel_d   = sel_sw_i;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (lat_q == LAT_LAST) begin
          res_d   = alu_res_i;
          cy_d    = alu_carry_i;
          valid_d = 1'b1;
          state_d = S_SHOW;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      S_SHOW: begin
        // Manual press outranks an auto expiry in the same cycle.
        if (press_q) begin
          state_d = S_LOAD_A;
        end else if (auto_i) begin
          if (tmr_q == AUTO_LAST) begin
            sel_d   = sel_q + 3'd1;
            state_d = S_EXEC;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
      end
      default: state_d = S_LOAD_A;
    endcase
  end

  // FSM and datapath registers; reset aborts any EXEC without a VALID pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      valid_q <= 1'b0;
      lat_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      valid_q <= valid_d;
      lat_q   <= lat_d;
      tmr_q   <= tmr_d;
    end
  end

  assign a_o      = a_q;
  assign b_o      = b_q;
  assign sel_o    = sel_q;
  assign res_o    = res_q;
  assign cambio_o = cy_q;
  assign state_o  = state_q;
  assign valid_o  = valid_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (ALU_LAT=1 and ALU_LAT=3) with
// separate button/auto/reset, random step sequences checked against a
// transaction-level model, plus bounce, auto-wrap, dropped-press and reset cases.
module tb_alu_op_sequencer;

  localparam int DEB  = 4;
  localparam int AUTO = 20;

  logic       clk;
  logic [3:0] sw;
  logic [2:0] sel_sw;
  logic       btn_v  [2];
  logic       auto_v [2];
  logic       rstn_v [2];
  logic [3:0] in_res [2];
  logic       in_cy  [2];
  logic [3:0] o_a    [2];
  logic [3:0] o_b    [2];
  logic [2:0] o_sel  [2];
  logic [3:0] o_res  [2];
  logic       o_cy   [2];
  logic [1:0] o_st   [2];
  logic       o_vld  [2];

  int lat_of [2] = '{1, 3};
  int total = 0;
  int bad   = 0;

  // model state per instance
  logic [3:0] m_a   [2];
  logic [3:0] m_b   [2];
  logic [2:0] m_sel [2];
  logic [3:0] m_res [2];
  logic       m_cy  [2];
  logic [1:0] m_st  [2];

  // bench ALU: op 0 add (carry), op 1 subtract (borrow), others logic/shift
  function automatic logic [4:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
    case (s)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {a[3], a[2:0], 1'b0};
      3'd6:    return {a[0], 1'b0, a[3:1]};
      default: return {1'b0, ~a};
    endcase
  endfunction

  assign {in_cy[0], in_res[0]} = alu(o_a[0], o_b[0], o_sel[0]);
  assign {in_cy[1], in_res[1]} = alu(o_a[1], o_b[1], o_sel[1]);

  alu_op_sequencer #(.DEB_CYCLES(DEB), .AUTO_CYCLES(AUTO), .ALU_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rstn_v[0]), .sw_i(sw), .sel_sw_i(sel_sw), .btn_i(btn_v[0]),
    .auto_i(auto_v[0]), .alu_res_i(in_res[0]), .alu_carry_i(in_cy[0]),
    .a_o(o_a[0]), .b_o(o_b[0]), .sel_o(o_sel[0]), .res_o(o_res[0]),
    .cambio_o(o_cy[0]), .state_o(o_st[0]), .valid_o(o_vld[0]));

  alu_op_sequencer #(.DEB_CYCLES(DEB), .AUTO_CYCLES(AUTO), .ALU_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rstn_v[1]), .sw_i(sw), .sel_sw_i(sel_sw), .btn_i(btn_v[1]),
    .auto_i(auto_v[1]), .alu_res_i(in_res[1]), .alu_carry_i(in_cy[1]),
    .a_o(o_a[1]), .b_o(o_b[1]), .sel_o(o_sel[1]), .res_o(o_res[1]),
    .cambio_o(o_cy[1]), .state_o(o_st[1]), .valid_o(o_vld[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset(input int d);
    m_a[d] = '0; m_b[d] = '0; m_sel[d] = '0; m_res[d] = '0; m_cy[d] = 1'b0; m_st[d] = 2'd0;
  endtask

  task automatic check_outs(input int d);
    chk("a", o_a[d], m_a[d]);
    chk("b", o_b[d], m_b[d]);
    chk("sel", o_sel[d], m_sel[d]);
    chk("res", o_res[d], m_res[d]);
    chk("cambio", o_cy[d], m_cy[d]);
    chk("state", o_st[d], m_st[d]);
  endtask

  task automatic check_zero(input int d);
    chk("z_a", o_a[d], 0);
    chk("z_b", o_b[d], 0);
    chk("z_sel", o_sel[d], 0);
    chk("z_res", o_res[d], 0);
    chk("z_cambio", o_cy[d], 0);
    chk("z_state", o_st[d], 0);
    chk("z_valid", o_vld[d], 0);
  endtask

  // clean button press; returns right after the edge where STATE moves
  task automatic press(input int d, input logic [3:0] s, input logic [2:0] ss);
    logic [1:0] old;
    int n;
    sw = s;
    sel_sw = ss;
    old = o_st[d];
    btn_v[d] = 1'b1;
    n = 0;
    while (o_st[d] == old && n < 30) begin
      tick();
      n++;
    end
    btn_v[d] = 1'b0;
    chk("press_lat", n, DEB + 4);
    case (old)
      2'd0: begin m_a[d] = s; m_st[d] = 2'd1; end
      2'd1: begin m_b[d] = s; m_sel[d] = ss; m_st[d] = 2'd2; end
      2'd3: m_st[d] = 2'd0;
      default: ;
    endcase
    chk("press_st", o_st[d], m_st[d]);
  endtask

  // one step: press, watch for the result pulse, let the release settle, check
  task automatic run_step(input int d, input logic [3:0] s, input logic [2:0] ss);
    logic [1:0] old;
    logic [1:0] sv;
    int nv, kv;
    old = o_st[d];
    press(d, s, ss);
    nv = 0; kv = -1; sv = 2'd0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (o_vld[d]) begin
        nv++;
        if (kv < 0) begin kv = k; sv = o_st[d]; end
      end
    end
    if (old == 2'd1) begin
      chk("vld_cnt", nv, 1);
      chk("vld_lat", kv, lat_of[d]);
      chk("vld_st", sv, 3);
      {m_cy[d], m_res[d]} = alu(m_a[d], m_b[d], m_sel[d]);
      m_st[d] = 2'd3;
    end else begin
      chk("no_vld", nv, 0);
    end
    check_outs(d);
  endtask

  initial begin
    int nz, nv, kv, ntr;
    int vt [3];
    int vs [3];
    logic saw_a;
    logic [1:0] prev;

    sw = '0; sel_sw = '0;
    for (int d = 0; d < 2; d++) begin
      btn_v[d] = 1'b0; auto_v[d] = 1'b0; rstn_v[d] = 1'b0;
      model_reset(d);
    end

    // 1. reset and quiet idle
    repeat (3) tick();
    check_zero(0);
    check_zero(1);
    rstn_v[0] = 1'b1;
    rstn_v[1] = 1'b1;
    nz = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      for (int d = 0; d < 2; d++)
        if (o_a[d] != 0 || o_b[d] != 0 || o_sel[d] != 0 || o_res[d] != 0 ||
            o_cy[d] != 0 || o_st[d] != 0 || o_vld[d] != 0) nz++;
    end
    chk("idle_nonzero", nz, 0);

    // 2. full step sequence 9 + 8 on both latencies
    for (int d = 0; d < 2; d++) begin
      run_step(d, 4'd9, 3'd0);
      run_step(d, 4'd8, 3'd0);
      chk("s2_res", o_res[d], 1);
      chk("s2_cy", o_cy[d], 1);
    end

    // random step rounds: SHOW -> LOAD_A -> LOAD_B -> EXEC -> SHOW
    for (int r = 0; r < 4; r++)
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 3; p++)
          run_step(d, 4'($urandom_range(15)), 3'($urandom_range(7)));

    // 3. bounce on instance 0, starting in LOAD_A
    run_step(0, 4'd0, 3'd0);
    sw = 4'($urandom_range(15));
    btn_v[0] = 1'b1;
    repeat (3) tick();
    btn_v[0] = 1'b0;
    repeat (15) tick();
    chk("short_pulse_st", o_st[0], 0);
    ntr = 0;
    prev = o_st[0];
    for (int k = 0; k < 30; k++) begin
      if (k < 10) btn_v[0] = k[0] ? 1'b0 : 1'b1;
      else if (k < 20) btn_v[0] = 1'b1;
      else btn_v[0] = 1'b0;
      tick();
      if (o_st[0] != prev) ntr++;
      prev = o_st[0];
    end
    btn_v[0] = 1'b0;
    repeat (10) tick();
    chk("bounce_adv", ntr, 1);
    m_a[0] = sw;
    m_st[0] = 2'd1;
    check_outs(0);

    // 4. auto wrap from SEL=7 on instance 0
    run_step(0, 4'($urandom_range(15)), 3'd7);
    auto_v[0] = 1'b1;
    nv = 0;
    for (int i = 0; i < 3; i++) begin vt[i] = -1; vs[i] = -1; end
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (o_vld[0]) begin
        if (nv < 3) begin vt[nv] = k; vs[nv] = o_sel[0]; end
        nv++;
      end
    end
    auto_v[0] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (o_vld[0]) nv++;
    end
    chk("auto_pulses", nv, 3);
    for (int i = 0; i < 3; i++) begin
      chk("auto_time", vt[i], 21 * (i + 1));
      chk("auto_sel", vs[i], i);
    end
    m_sel[0] = 3'd2;
    {m_cy[0], m_res[0]} = alu(m_a[0], m_b[0], m_sel[0]);
    check_outs(0);

    // 5. press landing in the 2nd EXEC cycle of an auto step (ALU_LAT=3)
    run_step(1, 4'd0, 3'd0);
    run_step(1, 4'd5, 3'd0);
    run_step(1, 4'd3, 3'd0);
    chk("s5_res", o_res[1], 8);
    auto_v[1] = 1'b1;
    nv = 0; kv = -1; saw_a = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 14) btn_v[1] = 1'b1;
      if (k == 24) btn_v[1] = 1'b0;
      if (k == 26) auto_v[1] = 1'b0;
      if (o_vld[1]) begin nv++; kv = k; end
      if (o_st[1] == 2'd0) saw_a = 1'b1;
    end
    repeat (10) tick();
    if (o_st[1] == 2'd0) saw_a = 1'b1;
    chk("drop_vld_cnt", nv, 1);
    chk("drop_vld_t", kv, 23);
    chk("drop_no_loada", saw_a, 0);
    m_sel[1] = 3'd1;
    {m_cy[1], m_res[1]} = alu(m_a[1], m_b[1], m_sel[1]);
    check_outs(1);
    chk("s5_sub_res", o_res[1], 2);

    // 6. reset in the 2nd EXEC cycle (ALU_LAT=3)
    run_step(1, 4'd0, 3'd0);
    run_step(1, 4'd6, 3'd0);
    press(1, 4'd2, 3'd0);
    tick();
    rstn_v[1] = 1'b0;
    #1;
    check_zero(1);
    model_reset(1);
    tick();
    tick();
    rstn_v[1] = 1'b1;
    nv = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (o_vld[1]) nv++;
    end
    chk("rst_exec_vld", nv, 0);
    check_outs(1);

    // button held through reset release counts as a fresh press
    sw = 4'($urandom_range(15));
    btn_v[1] = 1'b1;
    rstn_v[1] = 1'b0;
    tick();
    rstn_v[1] = 1'b1;
    nv = 0;
    while (o_st[1] == 2'd0 && nv < 30) begin
      tick();
      nv++;
    end
    btn_v[1] = 1'b0;
    chk("held_rst_lat", nv, DEB + 4);
    m_a[1] = sw;
    m_st[1] = 2'd1;
    repeat (12) tick();
    check_outs(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
